// File: rtl/camera_pkg.sv
// camera_pkg: types shared by the camera pipeline stages.
// Holds the coordinate width, the Bayer position codes and the line-buffer word layout.
package camera_pkg;

  localparam int COORD_W = 12;
  localparam int PIX_W   = 8;

  typedef enum logic [1:0] {
    BAYER_G1 = 2'b00,
    BAYER_R  = 2'b01,
    BAYER_B  = 2'b10,
    BAYER_G2 = 2'b11
  } bayer_t;

  // One buffered even-row pair: red in the upper half.
  typedef struct packed {
    logic [PIX_W-1:0] r;
    logic [PIX_W-1:0] g1;
  } lb_word_t;

  function automatic bayer_t bayer_pos(
    input logic y0,
    input logic x0
  );
    return bayer_t'({y0, x0});
  endfunction

endpackage

// File: rtl/raw_line_buffer.sv
// raw_line_buffer: simple dual-port RAM holding one row of {R, G1} pairs.
// Ports: clock; write port wr_en/wr_addr/wr_data; read port rd_en/rd_addr, registered rd_data held when idle.
module raw_line_buffer #(
  parameter int DEPTH = 1280,
  parameter int DW    = 16,
  parameter int AW    = 11
) (
  input  logic          clock,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/raw_to_rgb.sv
// raw_to_rgb: Bayer demosaic, one RGB pixel per 2x2 quad (G1 R / B G2).
// Ports: clock, reset_n (sync, active-low); in_width/in_height (RGB size);
// in_valid/in_data/in_count_x/in_count_y raw stream; out_valid, out_red/green/blue,
// out_x/out_y, out_done, sticky out_sync_error. Optional out_gray with RAW_TO_RGB_GRAY_EN.
module raw_to_rgb
  import camera_pkg::*;
#(
  parameter int N         = 8,
  parameter int MAX_WIDTH = 1280
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [COORD_W-1:0] in_width,
  input  logic [COORD_W-1:0] in_height,
  input  logic               in_valid,
  input  logic [N-1:0]       in_data,
  input  logic [COORD_W-1:0] in_count_x,
  input  logic [COORD_W-1:0] in_count_y,
  output logic               out_valid,
  output logic [N-1:0]       out_red,
  output logic [N-1:0]       out_green,
  output logic [N-1:0]       out_blue,
  output logic [COORD_W-1:0] out_x,
  output logic [COORD_W-1:0] out_y,
  output logic               out_done,
  output logic               out_sync_error
`ifdef RAW_TO_RGB_GRAY_EN
  ,
  output logic [N-1:0]       out_gray
`endif
);

  localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam logic [COORD_W-1:0] MAX_W = COORD_W'(MAX_WIDTH);
  localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

  logic [COORD_W-1:0] qx;
  logic [COORD_W-1:0] qy;
  logic               sof;
  logic               in_range;
  logic               act;
  logic               open_eff;
  bayer_t             pos;

  logic               pair_open;
  logic [N-1:0]       held;

  logic               hold_en;
  logic               wr_en;
  logic               rd_en;
  logic               emit;
  logic               err_set;
  logic               open_nxt;

  logic [2*N-1:0]     rd_word;
  logic [N-1:0]       buf_r;
  logic [N-1:0]       buf_g1;
  logic [N:0]         g_sum;
  logic [N-1:0]       green;
  logic               last_quad;

  assign qx = {1'b0, in_count_x[COORD_W-1:1]};
  assign qy = {1'b0, in_count_y[COORD_W-1:1]};
  assign sof = in_valid
             && (in_count_x == '0)
             && (in_count_y == '0);
  assign in_range = (qx < MAX_W)
                 && (qx < in_width)
                 && (qy < in_height);
  assign act = in_valid && in_range;
  // Start of frame wipes any stale half-pair before the pixel is used.
  assign open_eff = pair_open && !sof;
  assign pos = bayer_pos(in_count_y[0], in_count_x[0]);

  always_comb begin
    hold_en  = 1'b0;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    emit     = 1'b0;
    err_set  = 1'b0;
    open_nxt = open_eff;
    if (act) begin
      unique case (pos)
        BAYER_G1: begin
          hold_en  = 1'b1;
          open_nxt = 1'b1;
        end
        BAYER_B: begin
          hold_en  = 1'b1;
          rd_en    = 1'b1;
          open_nxt = 1'b1;
        end
        BAYER_R: begin
          if (open_eff) begin
            wr_en    = 1'b1;
            open_nxt = 1'b0;
          end else begin
            err_set = 1'b1;
          end
        end
        BAYER_G2: begin
          if (open_eff) begin
            emit     = 1'b1;
            open_nxt = 1'b0;
          end else begin
            err_set = 1'b1;
          end
        end
        default: begin
          open_nxt = open_eff;
        end
      endcase
    end
  end

  raw_line_buffer #(
    .DEPTH (MAX_WIDTH),
    .DW    (2*N),
    .AW    (AW)
  ) u_line_buffer (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_addr (qx[AW-1:0]),
    .wr_data ({in_data, held}),
    .rd_en   (rd_en),
    .rd_addr (qx[AW-1:0]),
    .rd_data (rd_word)
  );

  assign buf_r  = rd_word[2*N-1:N];
  assign buf_g1 = rd_word[N-1:0];

  // Average of the two greens, truncated.
  assign g_sum = {1'b0, buf_g1} + {1'b0, in_data};
  assign green = g_sum[N:1];

  assign last_quad = (qx == in_width - ONE)
                  && (qy == in_height - ONE);

`ifdef RAW_TO_RGB_GRAY_EN
  logic [N+1:0] gray_sum;

  assign gray_sum = {2'b00, buf_r}
                  + {1'b0, green, 1'b0}
                  + {2'b00, held};

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      out_gray <= '0;
    end else if (emit) begin
      out_gray <= gray_sum[N+1:2];
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pair_open      <= 1'b0;
      held           <= '0;
      out_valid      <= 1'b0;
      out_done       <= 1'b0;
      out_sync_error <= 1'b0;
      out_red        <= '0;
      out_green      <= '0;
      out_blue       <= '0;
      out_x          <= '0;
      out_y          <= '0;
    end else begin
      pair_open      <= open_nxt;
      out_valid      <= emit;
      out_done       <= emit && last_quad;
      out_sync_error <= err_set
                     || (out_sync_error && !sof);
      if (hold_en) begin
        held <= in_data;
      end
      if (emit) begin
        out_red   <= buf_r;
        out_green <= green;
        out_blue  <= held;
        out_x     <= qx;
        out_y     <= qy;
      end
    end
  end

endmodule

// File: tb/tb_raw_to_rgb.sv
// tb_raw_to_rgb: directed bench for raw_to_rgb with an image-array model.
// Build with RAW_TO_RGB_GRAY_EN to also check out_gray.
module tb_raw_to_rgb;

  localparam int N    = 8;
  localparam int MAXW = 2;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [11:0] in_width = 12'd2;
  logic [11:0] in_height = 12'd1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic [11:0] in_count_x = '0;
  logic [11:0] in_count_y = '0;
  logic        out_valid;
  logic [7:0]  out_red;
  logic [7:0]  out_green;
  logic [7:0]  out_blue;
  logic [11:0] out_x;
  logic [11:0] out_y;
  logic        out_done;
  logic        out_sync_error;
`ifdef RAW_TO_RGB_GRAY_EN
  logic [7:0]  out_gray;
`endif

  raw_to_rgb #(
    .N         (N),
    .MAX_WIDTH (MAXW)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .in_width       (in_width),
    .in_height      (in_height),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_count_x     (in_count_x),
    .in_count_y     (in_count_y),
    .out_valid      (out_valid),
    .out_red        (out_red),
    .out_green      (out_green),
    .out_blue       (out_blue),
    .out_x          (out_x),
    .out_y          (out_y),
    .out_done       (out_done),
    .out_sync_error (out_sync_error)
`ifdef RAW_TO_RGB_GRAY_EN
    ,
    .out_gray       (out_gray)
`endif
  );

  always #5 clock = ~clock;

  int n_run = 0;
  int n_fail = 0;
  int n_out = 0;
  bit started = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: raw image kept as a 2D array; a quad is formed from its four pixels.
  int img [0:7][0:7];
  bit m_open, m_sync, e_v, e_done;
  int e_r, e_g, e_b, e_x, e_y, e_gray;
  int mx, my, mqx, mqy;

  always @(posedge clock) begin
    e_v = 0;
    e_done = 0;
    if (!reset_n) begin
      m_open = 0;
      m_sync = 0;
    end else if (in_valid) begin
      mx = int'(in_count_x);
      my = int'(in_count_y);
      mqx = mx / 2;
      mqy = my / 2;
      if (mx == 0 && my == 0) begin
        m_sync = 0;
        m_open = 0;
      end
      if (mqx < MAXW && mqx < int'(in_width) && mqy < int'(in_height)) begin
        if (mx % 2 == 0) begin
          img[my][mx] = int'(in_data);
          m_open = 1;
        end else if (!m_open) begin
          m_sync = 1;
        end else begin
          img[my][mx] = int'(in_data);
          m_open = 0;
          if (my % 2 == 1) begin
            e_v = 1;
            e_r = img[my-1][mx];
            e_g = (img[my-1][mx-1] + img[my][mx]) / 2;
            e_b = img[my][mx-1];
            e_gray = (e_r + 2 * e_g + e_b) / 4;
            e_x = mqx;
            e_y = mqy;
            e_done = (mqx == int'(in_width) - 1)
                  && (mqy == int'(in_height) - 1);
          end
        end
      end
    end
  end

  always @(negedge clock) begin
    if (started) begin
      chk("out_valid", out_valid, e_v);
      chk("out_done", out_done, e_done);
      chk("out_sync_error", out_sync_error, m_sync);
      if (out_valid) n_out++;
      if (out_valid && e_v) begin
        chk("out_red", out_red, e_r);
        chk("out_green", out_green, e_g);
        chk("out_blue", out_blue, e_b);
        chk("out_x", out_x, e_x);
        chk("out_y", out_y, e_y);
`ifdef RAW_TO_RGB_GRAY_EN
        chk("out_gray", out_gray, e_gray);
`endif
      end
    end
  end

  task automatic px(int x, int y, int d);
    in_valid = 1'b1;
    in_count_x = 12'(x);
    in_count_y = 12'(y);
    in_data = 8'(d);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // W=2, H=1 reference frame with literal expectations.
  task automatic frame_a(int gap);
    px(0, 0, 10);  idle(gap);
    px(1, 0, 200); idle(gap);
    px(2, 0, 30);  idle(gap);
    px(3, 0, 40);  idle(gap);
    px(0, 1, 50);  idle(gap);
    px(1, 1, 60);
    chk("a_q0_valid", out_valid, 1);
    chk("a_q0_red", out_red, 200);
    chk("a_q0_green", out_green, 35);
    chk("a_q0_blue", out_blue, 50);
    chk("a_q0_done", out_done, 0);
`ifdef RAW_TO_RGB_GRAY_EN
    chk("a_q0_gray", out_gray, 80);
`endif
    idle(gap);
    px(2, 1, 70);  idle(gap);
    px(3, 1, 80);
    chk("a_q1_valid", out_valid, 1);
    chk("a_q1_red", out_red, 40);
    chk("a_q1_green", out_green, 55);
    chk("a_q1_blue", out_blue, 70);
    chk("a_q1_x", out_x, 1);
    chk("a_q1_done", out_done, 1);
    idle(1);
    chk("a_done_pulse", out_done, 0);
  endtask

  int base;

  initial begin
    @(posedge clock);
    #1;
    started = 1;
    idle(1);
    chk("rst_valid", out_valid, 0);
    chk("rst_red", out_red, 0);
    chk("rst_done", out_done, 0);
    chk("rst_sync", out_sync_error, 0);
    reset_n = 1'b1;
    idle(2);

    frame_a(0);
    idle(2);
    frame_a(3);
    idle(2);

    px(1, 1, 99);
    chk("se_no_valid", out_valid, 0);
    chk("se_flag", out_sync_error, 1);
    px(3, 0, 5);
    idle(3);
    chk("se_sticky", out_sync_error, 1);
    px(0, 0, 10);
    chk("se_cleared", out_sync_error, 0);
    idle(1);
    frame_a(0);

    in_width = 12'd1;
    in_height = 12'd1;
    px(0, 0, 255); px(1, 0, 9); px(2, 0, 1); px(3, 0, 2);
    px(0, 1, 7);   px(1, 1, 255);
    chk("g_max_green", out_green, 255);
    chk("g_max_done", out_done, 1);
    px(2, 1, 3);   px(3, 1, 4);
    chk("w_clip_none", out_valid, 0);
    px(0, 2, 1); px(1, 2, 2); px(0, 3, 3); px(1, 3, 4);
    chk("h_clip_none", out_valid, 0);
    px(0, 0, 255); px(1, 0, 9); px(0, 1, 7); px(1, 1, 0);
    chk("g_half_green", out_green, 127);
    chk("g_half_red", out_red, 9);
    idle(2);

    in_width = 12'd4;
    base = n_out;
    for (int x = 0; x < 8; x++) px(x, 0, 10 * x + 10);
    for (int x = 0; x < 8; x++) px(x, 1, 10 * x + 11);
    idle(2);
    chk("max_w_count", n_out - base, 2);

    in_width = 12'd2;
    px(0, 0, 10); px(1, 0, 200); px(2, 0, 30); px(3, 0, 40);
    px(0, 1, 50);
    reset_n = 1'b0;
    idle(2);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_red", out_red, 0);
    chk("mid_rst_green", out_green, 0);
    reset_n = 1'b1;
    px(1, 1, 60);
    chk("mid_rst_novalid", out_valid, 0);
    chk("mid_rst_sync", out_sync_error, 1);
    idle(1);
    frame_a(0);

    idle(3);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
